// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu -- iterative multiply/divide unit that sits beside the execute ALU.
//
// Takes one MUL / MULH / DIV / REM request per valid/ready transaction. It
// computes one bit per cycle on operand magnitudes: shift-add for multiply and
// restoring division for divide. The result sign is applied in a single
// fix-up cycle. The result is returned together with the destination tag of
// its request.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous reset, active-low
//   req_valid   request present
//   req_ready   unit can accept a request this cycle
//   req_op      00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM
//   req_signed  1: operands are two's complement, 0: unsigned
//   req_a       multiplicand / dividend
//   req_b       multiplier / divisor
//   req_tag     destination register, returned unchanged with the result
//   flush       abort any in-flight operation and discard its result
//   rsp_valid   result available (held until rsp_ready)
//   rsp_ready   consumer takes the result
//   rsp_data    result
//   rsp_tag     tag of the request that produced rsp_data
//   rsp_div0    DIV/REM issued with req_b == 0
//   busy        unit is not idle
// -----------------------------------------------------------------------------
module alu_mdu #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_div0,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  // Control state (reset)
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_div0_q, rsp_div0_d;

  // Datapath state (loaded on accept)
  logic [PW-1:0]    acc_q, acc_d;   // {hi/remainder, lo/quotient}
  logic [WIDTH-1:0] dvs_q, dvs_d;   // multiplicand or divisor magnitude
  op_e              op_q, op_d;
  logic             neg_q, neg_d;   // result must be negated in FIXUP
  logic [TAG_W-1:0] tag_q, tag_d;

  // Combinational helpers
  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_step;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;
  logic [PW-1:0]    div_step;
  logic [PW-1:0]    prod_signed;
  logic [WIDTH-1:0] div_sel, div_res, mul_res, fix_res;

  assign req_ready = (state_q == S_IDLE) & rst & ~flush;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_div0  = rsp_div0_q;

  // Operand magnitudes. -2^(WIDTH-1) negates to itself. Read as unsigned,
  // that is exactly 2^(WIDTH-1), so the datapath needs no extra bit.
  always_comb begin
    a_neg = req_signed & req_a[WIDTH-1];
    b_neg = req_signed & req_b[WIDTH-1];
    a_mag = a_neg ? (~req_a) + WIDTH'(1) : req_a;
    b_mag = b_neg ? (~req_b) + WIDTH'(1) : req_b;
  end

  // One iteration of each algorithm, plus the sign/half selection for FIXUP.
  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: bring the next dividend bit into the partial
    // remainder and subtract the divisor only if it fits. The remainder is
    // always below the divisor, so the WIDTH-bit difference is exact.
    div_shift = acc_q[PW-1:WIDTH-1];
    div_trial = div_shift[WIDTH-1:0] - dvs_q;
    div_ge    = (div_shift >= {1'b0, dvs_q});
    div_step  = {(div_ge ? div_trial : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // Negate the full product before taking a half, so MULH sees the borrow.
    prod_signed = neg_q ? (~acc_q) + PW'(1) : acc_q;
    mul_res     = (op_q == OP_MUL) ? prod_signed[WIDTH-1:0] : prod_signed[PW-1:WIDTH];
    div_sel     = (op_q == OP_DIV) ? acc_q[WIDTH-1:0] : acc_q[PW-1:WIDTH];
    div_res     = neg_q ? (~div_sel) + WIDTH'(1) : div_sel;
    fix_res     = op_q[1] ? div_res : mul_res;
  end

  always_comb begin
    // NOTE: every *_d takes its hold value first, so every path through this
    // block assigns every signal and no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_div0_d  = rsp_div0_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    neg_d       = neg_q;
    tag_d       = tag_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_e'(req_op);
          tag_d = req_tag;
          cnt_d = '0;
          // REM takes the dividend's sign. MUL and DIV take the XOR of both signs.
          neg_d = (req_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
          if (req_op[1] && (req_b == '0)) begin
            // Divide by zero skips the iteration and uses the raw operand.
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_div0_d  = 1'b1;
            rsp_tag_d   = req_tag;
            rsp_data_d  = req_op[0] ? req_a : '1;
          end else begin
            state_d = S_CALC;
            if (req_op[1]) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              dvs_d = b_mag;
            end else begin
              acc_d = {{WIDTH{1'b0}}, b_mag};
              dvs_d = a_mag;
            end
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_step : mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_div0_d  = 1'b0;
        rsp_data_d  = fix_res;
        rsp_tag_d   = tag_q;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_div0_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything. The pending or finished result is dropped.
    if (flush) begin
      state_d     = S_IDLE;
      rsp_valid_d = 1'b0;
      rsp_div0_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_div0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_div0_q  <= rsp_div0_d;
    end
  end

  // NOTE: the datapath registers are intentionally left without reset. They
  // are always written on accept before anything reads them, and only the
  // reset control state decides what reaches the outputs.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    dvs_q <= dvs_d;
    op_q  <= op_d;
    neg_q <= neg_d;
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu -- directed scoreboard bench for alu_mdu (WIDTH=16, TAG_W=3).
// The driver pushes the expected response for each accepted request. The
// monitor compares every cycle in which rsp_valid is high against the head of
// the queue and pops the entry on the handshake.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

  localparam int W  = 16;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic          req_signed;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [TW-1:0] req_tag;
  logic          flush;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_div0;
  logic          busy;

  alu_mdu #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_signed(req_signed),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_div0  (rsp_div0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          div0;
    int            lat;
    int            issue_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rsp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // Presents one request and returns at the negedge after it was accepted.
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic [W-1:0] exp_data, input logic exp_div0, input bit push);
    int waited;
    int lat;
    lat    = (op[1] && b == '0) ? 1 : 18;
    waited = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_signed = sgn;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    #1;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) fail_now("accept_timeout");
    else if (push) sb.push_back('{data: exp_data, tag: tag, div0: exp_div0, lat: lat, issue_cyc: cyc});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    #3;
    while ((sb.size() != 0 || rsp_valid) && w < 400) begin
      @(negedge clk);
      #3;
      w++;
    end
    if (sb.size() != 0 || rsp_valid) fail_now("drain_timeout");
  endtask

  // Monitor: samples 2 time units after each negedge, when inputs are settled.
  bit in_rsp = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          rsp_seen++;
        end
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: data 0x%0h tag %0d with no request pending (cycle %0d)",
                   rsp_data, rsp_tag, cyc);
        end else begin
          if (cyc - sb[0].issue_cyc <= sb[0].lat)
            check("rsp_latency", cyc - sb[0].issue_cyc, sb[0].lat);
          check("rsp_data", rsp_data, sb[0].data);
          check("rsp_tag", rsp_tag, sb[0].tag);
          check("rsp_div0", rsp_div0, sb[0].div0);
          if (rsp_ready) begin
            void'(sb.pop_front());
            in_rsp = 1'b0;
          end
        end
      end else begin
        in_rsp = 1'b0;
        if (rsp_div0 !== 1'b0) check("div0_without_valid", rsp_div0, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    flush      = 1'b0;
    rsp_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_tag", rsp_tag, 0);
    check("reset_rsp_div0", rsp_div0, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("idle_req_ready", req_ready, 1);

    // Multiply
    issue(2'b00, 1'b0, 16'h0123, 16'h0045, 3'd5, 16'h4E6F, 1'b0, 1'b1);
    issue(2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0000, 1'b0, 1'b1);
    issue(2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 3'd2, 16'hFFFE, 1'b0, 1'b1);
    issue(2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0001, 1'b0, 1'b1);
    issue(2'b00, 1'b1, 16'h8000, 16'h8000, 3'd4, 16'h0000, 1'b0, 1'b1);
    issue(2'b01, 1'b1, 16'h8000, 16'h8000, 3'd6, 16'h4000, 1'b0, 1'b1);
    issue(2'b01, 1'b1, 16'h0003, 16'hFFFE, 3'd0, 16'hFFFF, 1'b0, 1'b1);

    // Divide / remainder
    issue(2'b10, 1'b1, 16'hFFF9, 16'h0002, 3'd4, 16'hFFFD, 1'b0, 1'b1);
    issue(2'b11, 1'b1, 16'hFFF9, 16'h0002, 3'd6, 16'hFFFF, 1'b0, 1'b1);
    issue(2'b10, 1'b0, 16'h0064, 16'h0007, 3'd7, 16'h000E, 1'b0, 1'b1);
    issue(2'b11, 1'b0, 16'h0064, 16'h0007, 3'd0, 16'h0002, 1'b0, 1'b1);
    issue(2'b10, 1'b1, 16'h8000, 16'hFFFF, 3'd3, 16'h8000, 1'b0, 1'b1);
    issue(2'b11, 1'b1, 16'h8000, 16'hFFFF, 3'd4, 16'h0000, 1'b0, 1'b1);

    // Divide by zero, unsigned and signed (signed flag ignored)
    issue(2'b10, 1'b0, 16'h1234, 16'h0000, 3'd1, 16'hFFFF, 1'b1, 1'b1);
    issue(2'b11, 1'b0, 16'h1234, 16'h0000, 3'd2, 16'h1234, 1'b1, 1'b1);
    issue(2'b11, 1'b1, 16'hFFF9, 16'h0000, 3'd5, 16'hFFF9, 1'b1, 1'b1);
    issue(2'b10, 1'b1, 16'hFFF9, 16'h0000, 3'd6, 16'hFFFF, 1'b1, 1'b1);
    wait_done();

    // Back-pressure: result held with rsp_ready low, no new accept meanwhile
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(2'b00, 1'b1, 16'h0003, 16'hFFFE, 3'd7, 16'hFFFA, 1'b0, 1'b1);
    w = 0;
    #3;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      #3;
      w++;
    end
    if (!rsp_valid) fail_now("hold_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #3;
    check("hold_last_req_ready", req_ready, 0);
    @(negedge clk);
    #3;
    check("post_hs_rsp_valid", rsp_valid, 0);
    check("post_hs_req_ready", req_ready, 1);

    // flush and req_valid in the same idle cycle: flush wins
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 16'h0002;
    req_b     = 16'h0003;
    flush     = 1'b1;
    #3;
    check("flush_idle_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #3;
    check("flush_idle_busy", busy, 0);

    // Flush 5 cycles after accept: result never appears
    base = rsp_seen;
    issue(2'b00, 1'b0, 16'h1111, 16'h0003, 3'd2, 16'h3333, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #3;
    check("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("flush_busy", busy, 0);
    check("flush_rsp_valid", rsp_valid, 0);
    repeat (25) @(negedge clk);
    check("flush_no_rsp", rsp_seen - base, 0);

    // Operation after flush completes normally
    issue(2'b00, 1'b0, 16'h00FF, 16'h0101, 3'd6, 16'hFFFF, 1'b0, 1'b1);
    wait_done();

    // Reset mid-CALC: all outputs cleared, result lost
    base = rsp_seen;
    issue(2'b10, 1'b0, 16'h7FFF, 16'h0003, 3'd5, 16'h2AAA, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_tag", rsp_tag, 0);
    check("midrst_rsp_div0", rsp_div0, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_rsp", rsp_seen - base, 0);

    // Recovery after reset
    issue(2'b10, 1'b0, 16'h7FFF, 16'h0003, 3'd5, 16'h2AAA, 1'b0, 1'b1);
    wait_done();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
